audio_dac_tx: RTL and testbench
===============================

Name: audio_dac_tx

Overview:
- Downstream output stage of the pedal board.
- Takes the processed mono 16-bit sample (Signal_out of the effects chain) and serialises it to the board audio codec DAC in I2S format.
- Generates the codec bit clock and LR clock. Sends the same sample on left and right.
- Issues a once-per-frame sample request strobe so upstream stages can pace themselves to the audio frame rate.

Parameters:
- CLK_DIV, 16, Clk cycles per BCLK half-period. Legal range is 2..255. The default gives BCLK = Clk/32 and fs = Clk/1024 (48.83 kHz at 50 MHz).

Ports:
- Clk  input  1  system clock; all logic on rising edge
- RESET  input  1  synchronous, active-high reset
- sample_in  input  16  signed two's-complement sample from the effects chain
- sample_valid  input  1  sample_in holds a fresh sample
- sample_req  output  1  one-Clk pulse; sample_in/sample_valid are captured in this cycle
- underrun  output  1  sticky flag; a capture occurred with sample_valid=0
- AUD_BCLK  output  1  codec bit clock
- AUD_DACLRCK  output  1  codec LR clock; 0 = left, 1 = right
- AUD_DACDAT  output  1  serial data, MSB first, I2S one-bit delay

Behaviour:
- Reset values, all outputs registered:
  - div_cnt=0, AUD_BCLK=0, AUD_DACLRCK=1, AUD_DACDAT=0, slot=31.
  - cur_word=0, sample_req=0, underrun=0.
- RESET is sampled every cycle. Asserting it mid-frame aborts the frame and returns every register to its reset value in the next cycle. No partial word is resumed.
- Divider:
  - div_cnt counts 0..CLK_DIV-1.
  - At terminal count, div_cnt wraps to 0 and AUD_BCLK toggles.
  - A toggle 1->0 is a "fall event". A toggle 0->1 is a "rise event".
- Slot counter:
  - slot (0..31) advances on each fall event, wrapping 31->0.
  - AUD_DACLRCK = 0 for slots 0..15 and 1 for slots 16..31. It is updated on the same fall event as slot.
- Data mapping on each fall event, with next slot value k:
  - k=0: cur_word[0] (last bit of the right channel).
  - k=1..15: cur_word[16-k].
  - k=16: cur_word[0].
  - k=17..31: cur_word[32-k].
  - Data therefore changes only on BCLK falling edges and is stable across the following rising edge.
- Capture, on the fall event with k=0:
  - AUD_DACDAT takes the old cur_word[0], using the pre-update value.
  - cur_word <= sample_in if sample_valid=1. Otherwise cur_word is unchanged (last sample repeated) and underrun <= 1.
  - sample_req=1 for exactly this one cycle; it is 0 in every other cycle.
- Timing:
  - Frame period is 64*CLK_DIV Clk cycles.
  - The first fall event, and therefore the first sample_req, occurs 2*CLK_DIV cycles after the last RESET-high cycle.
  - Latency from capture to the MSB appearing on AUD_DACDAT is 2*CLK_DIV cycles (the slot-1 fall event).
- Boundary cases:
  - sample_in may change at any time. Only the value in the sample_req cycle matters.
  - sample_valid is not stored; an upstream stage keeps it high for a free-running stream.
  - underrun clears only on RESET.
  - Full-scale values 16'h8000 and 16'h7FFF are transmitted bit-exact, with no saturation or processing.

Optional Feature:
- Macro: DAC_MUTE_EN.
- Defined:
  - Adds input port mute (1 bit), placed after sample_valid.
  - mute is sampled only at capture. If 1, cur_word <= 0 regardless of sample_valid, and underrun is not set for that capture.
  - Muting and unmuting take effect on whole frames only; a frame is never cut mid-word.
- Undefined: no mute port and no mute logic. Behaviour is exactly as above.

Test Plan:
- Reset release, CLK_DIV=4:
  - First sample_req pulse exactly 8 cycles after RESET falls, then every 256 cycles.
  - AUD_BCLK period is 8 cycles.
  - AUD_DACLRCK is low for 128 cycles, then high for 128.
- sample_in=16'hA5C3, sample_valid=1 at a capture:
  - Serial capture on BCLK rising edges gives 16'hA5C3 in left slots 1..16 and again in right slots 17..31 plus slot 0 of the next frame.
  - The MSB appears 8 cycles after sample_req.
- sample_valid=0 at one capture after 16'h1234 was sent:
  - The next frame retransmits 16'h1234.
  - underrun rises the cycle after that sample_req and stays 1 until RESET.
- RESET asserted for 1 cycle at slot 9:
  - Next cycle shows AUD_BCLK=0, AUD_DACLRCK=1, AUD_DACDAT=0, underrun=0.
  - Next sample_req occurs 8 cycles after RESET drops.
- Full scale: 16'h8000 then 16'h7FFF give the serial patterns 1 followed by fifteen 0s, then 0 followed by fifteen 1s.
- With DAC_MUTE_EN, mute=1 at capture and sample_in=16'h7FFF:
  - The whole frame transmits zeros and underrun stays 0.
  - After mute drops, the next frame carries the current sample_in.

Source files
------------

// File: rtl/audio_dac_tx_if.sv
// audio_dac_tx_if: sample handshake and codec-side serial lines of the
// pedal-board DAC output stage.
// Optional macro DAC_MUTE_EN adds the mute input sampled at each capture.
interface audio_dac_tx_if;
    logic [15:0] sample_in;
    logic        sample_valid;
`ifdef DAC_MUTE_EN
    logic        mute;
`endif
    logic        sample_req;
    logic        underrun;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_DACDAT;

`ifdef DAC_MUTE_EN
    // Upstream stage / test driver side
    modport master (output sample_in, output sample_valid, output mute,
                    input sample_req, input underrun,
                    input AUD_BCLK, input AUD_DACLRCK, input AUD_DACDAT);
    // DAC transmitter side
    modport slave  (input sample_in, input sample_valid, input mute,
                    output sample_req, output underrun,
                    output AUD_BCLK, output AUD_DACLRCK, output AUD_DACDAT);
`else
    // Upstream stage / test driver side
    modport master (output sample_in, output sample_valid,
                    input sample_req, input underrun,
                    input AUD_BCLK, input AUD_DACLRCK, input AUD_DACDAT);
    // DAC transmitter side
    modport slave  (input sample_in, input sample_valid,
                    output sample_req, output underrun,
                    output AUD_BCLK, output AUD_DACLRCK, output AUD_DACDAT);
`endif
endinterface

// File: rtl/audio_dac_tx.sv
// audio_dac_tx: serialises a mono 16-bit sample to the codec DAC in I2S
// format (same word on left and right), generating BCLK and LRCK, and
// pulses sample_req once per frame in the cycle the sample is captured.
// Optional macro DAC_MUTE_EN: mute input forces whole frames to zero.
module audio_dac_tx #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic           Clk,
    input  logic           RESET,
    audio_dac_tx_if.slave  bus
);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0]  div_cnt_q,  div_cnt_d;
    logic        bclk_q,     bclk_d;
    logic        lrck_q,     lrck_d;
    logic        dat_q,      dat_d;
    logic [4:0]  slot_q,     slot_d;
    logic [15:0] cur_word_q, cur_word_d;
    logic        req_q,      req_d;
    logic        under_q,    under_d;

    // Bit of the word sent in slot k: slots 1..15 and 17..31 walk down from
    // the MSB, slots 0 and 16 carry the LSB. 16-k and 32-k share the same
    // low four bits, so one modulo-16 negation covers every slot.
    function automatic logic slot_bit(input logic [15:0] word, input logic [4:0] k);
        logic [3:0] idx;
        idx = 4'd0 - k[3:0];
        return word[idx];
    endfunction

    // Next-state logic: divider, BCLK toggle, slot/LRCK/data on fall events,
    // and the sample capture in the cycle following the slot-0 fall event.
    always_comb begin
        div_cnt_d  = div_cnt_q;
        bclk_d     = bclk_q;
        lrck_d     = lrck_q;
        dat_d      = dat_q;
        slot_d     = slot_q;
        cur_word_d = cur_word_q;
        req_d      = 1'b0;
        under_d    = under_q;

        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = 8'd0;
            bclk_d    = ~bclk_q;
            if (bclk_q) begin
                // Fall event: the word still holds the previous sample here,
                // so slot 0 naturally sends the previous right-channel LSB.
                slot_d = slot_q + 5'd1;
                lrck_d = slot_d[4];
                dat_d  = slot_bit(cur_word_q, slot_d);
                req_d  = (slot_d == 5'd0);
            end else begin
                slot_d = slot_q;
            end
        end else begin
            div_cnt_d = div_cnt_q + 8'd1;
        end

        // Capture in the sample_req cycle; the next fall event is at least
        // three cycles away, so the new word is in place for the MSB slot.
        if (req_q) begin
`ifdef DAC_MUTE_EN
            if (bus.mute) begin
                cur_word_d = 16'd0;
            end else if (bus.sample_valid) begin
                cur_word_d = bus.sample_in;
            end else begin
                under_d = 1'b1;
            end
`else
            if (bus.sample_valid) begin
                cur_word_d = bus.sample_in;
            end else begin
                under_d = 1'b1;
            end
`endif
        end else begin
            cur_word_d = cur_word_q;
        end
    end

    // State registers with synchronous reset; a reset aborts any frame.
    always_ff @(posedge Clk) begin
        if (RESET) begin
            div_cnt_q  <= 8'd0;
            bclk_q     <= 1'b0;
            lrck_q     <= 1'b1;
            dat_q      <= 1'b0;
            slot_q     <= 5'd31;
            cur_word_q <= 16'd0;
            req_q      <= 1'b0;
            under_q    <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bclk_q     <= bclk_d;
            lrck_q     <= lrck_d;
            dat_q      <= dat_d;
            slot_q     <= slot_d;
            cur_word_q <= cur_word_d;
            req_q      <= req_d;
            under_q    <= under_d;
        end
    end

    assign bus.sample_req  = req_q;
    assign bus.underrun    = under_q;
    assign bus.AUD_BCLK    = bclk_q;
    assign bus.AUD_DACLRCK = lrck_q;
    assign bus.AUD_DACDAT  = dat_q;
endmodule

// File: tb/tb_audio_dac_tx.sv
// tb_audio_dac_tx: directed bench for audio_dac_tx with CLK_DIV=4.
// A time-based frame model checks every output every cycle; directed
// tasks recover serial words and timing and compare them to literals.
module tb_audio_dac_tx;
    localparam int D     = 4;
    localparam int FRAME = 64 * D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    audio_dac_tx_if dac_if ();
    audio_dac_tx #(.CLK_DIV(D)) dut (.Clk(clk), .RESET(rst), .bus(dac_if));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    // t = clock edges since the last reset edge. BCLK toggles every D edges;
    // fall number j = t/(2D); frame f starts at fall 32f+1 (slot 0) and
    // sample_req is the cycle right after that fall. words[f] is the word
    // carried in frame f's slots 1..31.
    int          t      = 0;
    bit          mvalid = 1'b0;
    logic [15:0] words[$];
    logic        m_under;

    always @(posedge clk) begin
        if (rst) begin
            t       = 0;
            m_under = 1'b0;
            words.delete();
            mvalid  = 1'b1;
        end else if (mvalid) begin
            if (t % FRAME == 2 * D) begin
                logic [15:0] nw;
                nw = (words.size() == 0) ? 16'h0000 : words[words.size()-1];
`ifdef DAC_MUTE_EN
                if (dac_if.mute) nw = 16'h0000;
                else if (dac_if.sample_valid) nw = dac_if.sample_in;
                else m_under = 1'b1;
`else
                if (dac_if.sample_valid) nw = dac_if.sample_in;
                else m_under = 1'b1;
`endif
                words.push_back(nw);
            end
            t = t + 1;
        end
    end

    // Compare every output against the model on every cycle.
    always @(negedge clk) begin
        if (mvalid) begin
            int j, k, f, slot;
            logic e_dat;
            j    = t / (2 * D);
            slot = (31 + j) % 32;
            e_dat = 1'b0;
            if (j >= 1) begin
                k = (j - 1) % 32;
                f = (j - 1) / 32;
                if (k == 0)       e_dat = (f == 0) ? 1'b0 : words[f-1][0];
                else if (k < 16)  e_dat = words[f][16-k];
                else if (k == 16) e_dat = words[f][0];
                else              e_dat = words[f][32-k];
            end
            chk("bclk",     {31'd0, dac_if.AUD_BCLK},    {31'd0, 1'((t / D) % 2)});
            chk("lrck",     {31'd0, dac_if.AUD_DACLRCK}, {31'd0, 1'(slot >= 16)});
            chk("dacdat",   {31'd0, dac_if.AUD_DACDAT},  {31'd0, e_dat});
            chk("req",      {31'd0, dac_if.sample_req},  {31'd0, 1'(t % FRAME == 2 * D)});
            chk("underrun", {31'd0, dac_if.underrun},    {31'd0, m_under});
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_req();
        int n;
        n = 0;
        while (dac_if.sample_req !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) timeout("wait_req");
    endtask

    // Present w/v in the next sample_req cycle, then read the left word off
    // BCLK rising edges (skip slot 0, take slots 1..16).
    task automatic grab(input logic [15:0] w, input logic v, output logic [15:0] got);
        int   n, rises;
        logic pb;
        got = 16'h0000;
        wait_req();
        dac_if.sample_in    = w;
        dac_if.sample_valid = v;
        pb = dac_if.AUD_BCLK;
        rises = 0;
        n = 0;
        while (rises < 17 && n < 1000) begin
            @(negedge clk);
            n++;
            if (dac_if.AUD_BCLK && !pb) begin
                rises++;
                if (rises > 1) got = {got[14:0], dac_if.AUD_DACDAT};
            end
            pb = dac_if.AUD_BCLK;
        end
        if (n >= 1000) timeout("grab");
    endtask

    initial begin
        int n, lo, msb_at, r1, r2;
        logic pb;
        logic [15:0] got;

        dac_if.sample_in    = 16'h0000;
        dac_if.sample_valid = 1'b1;
`ifdef DAC_MUTE_EN
        dac_if.mute         = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // First sample_req after reset release
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dac_if.sample_req !== 1'b1 && n < 1000);
        chk("first_req_delay", n, 8);

        // One frame: period, LRCK low time, MSB latency, BCLK period
        dac_if.sample_in = 16'hA5C3;
        n = 0; lo = 0; msb_at = -1; r1 = -1; r2 = -1;
        pb = dac_if.AUD_BCLK;
        do begin
            @(negedge clk);
            n++;
            if (!dac_if.AUD_DACLRCK) lo++;
            if (dac_if.AUD_DACDAT && msb_at < 0) msb_at = n;
            if (dac_if.AUD_BCLK && !pb) begin
                if (r1 < 0) r1 = n;
                else if (r2 < 0) r2 = n;
            end
            pb = dac_if.AUD_BCLK;
        end while (dac_if.sample_req !== 1'b1 && n < 1000);
        chk("frame_period", n, 256);
        chk("lrck_low",     lo, 128);
        chk("msb_latency",  msb_at, 8);
        chk("bclk_period",  r2 - r1, 8);

        grab(16'hA5C3, 1'b1, got);  chk("word_a5c3", got, 16'hA5C3);

        // Underrun: last good word repeats, flag sticks
        grab(16'h1234, 1'b1, got);  chk("word_1234", got, 16'h1234);
        grab(16'hFFFF, 1'b0, got);  chk("repeat_1234", got, 16'h1234);
        chk("underrun_set", dac_if.underrun, 1);
        grab(16'h0F0F, 1'b1, got);  chk("word_0f0f", got, 16'h0F0F);
        chk("underrun_sticky", dac_if.underrun, 1);

        // Mid-frame reset in slot 9
        wait_req();
        repeat (74) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_bclk",  dac_if.AUD_BCLK, 0);
        chk("rst_lrck",  dac_if.AUD_DACLRCK, 1);
        chk("rst_dat",   dac_if.AUD_DACDAT, 0);
        chk("rst_under", dac_if.underrun, 0);
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dac_if.sample_req !== 1'b1 && n < 1000);
        chk("req_after_rst", n, 8);

        // Full-scale words
        grab(16'h8000, 1'b1, got);  chk("word_8000", got, 16'h8000);
        grab(16'h7FFF, 1'b1, got);  chk("word_7fff", got, 16'h7FFF);

`ifdef DAC_MUTE_EN
        dac_if.mute = 1'b1;
        grab(16'h7FFF, 1'b0, got);  chk("mute_zero", got, 16'h0000);
        chk("mute_no_underrun", dac_if.underrun, 0);
        dac_if.mute = 1'b0;
        grab(16'h7FFF, 1'b1, got);  chk("unmute_7fff", got, 16'h7FFF);
`endif

        // Let the right channel and next slot 0 run under the model
        wait_req();
        repeat (FRAME) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
